// File: rtl/core_pkg.sv
// Shared core definitions: hazard-controller state encoding and the pipeline NOP word.
package core_pkg;

  typedef logic [1:0] hz_state_t;

  localparam hz_state_t StBoot    = 2'd0;
  localparam hz_state_t StRun     = 2'd1;
  localparam hz_state_t StMemWait = 2'd2;

  // addi x0, x0, 0 is not used; the canonical NOP here is add x0, x0, x0.
  localparam logic [31:0] Nop = 32'h0000_0033;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Performance counters for the hazard controller: stall cycles and redirect events.
module hazard_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        stall_inc_i,
  input  logic        flush_inc_i,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_events_o
);

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;

  // Clear wins over a same-cycle increment.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (clr_i) begin
      stall_cycles_d = '0;
      flush_events_d = '0;
    end else begin
      if (stall_inc_i) stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush_inc_i) flush_events_d = flush_events_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_events_o = flush_events_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: boot hold, load-use stalls, memory-wait stalls and
// mispredict redirects (deferred while memory is busy), with performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        use_rs1_d,
  input  logic        use_rs2_d,
  input  logic [4:0]  rd_e,
  input  logic        memread_e,
  input  logic        mispredict_e,
  input  logic [31:0] redirect_pc_e,
  input  logic        mem_busy,
  input  logic        cnt_clr,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        flush_d,
  output logic        bubble_e,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
);

  hz_state_t   state_q, state_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        load_use;
  logic        boot_done;

  assign load_use = memread_e & (rd_e != 5'd0) &
                    ((use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e)));

  assign boot_done = (32'(boot_cnt_q) + 32'd1) >= BOOT_CYCLES;

  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    flush_d        = 1'b0;
    bubble_e       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;

    case (state_q)
      StBoot: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
        if (boot_done) state_d = StRun;
        else           boot_cnt_d = boot_cnt_q + 8'd1;
      end
      StRun, StMemWait: begin
        if (mem_busy) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          state_d = StMemWait;
          // Younger mispredict overwrites any older pending target.
          if (mispredict_e) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_pc_e;
          end
        end else begin
          state_d = StRun;
          if (mispredict_e | pend_valid_q) begin
            redirect_valid = 1'b1;
            flush_d        = 1'b1;
            bubble_e       = 1'b1;
            redirect_pc    = mispredict_e ? redirect_pc_e : pend_pc_q;
            pend_valid_d   = 1'b0;
          end else if (load_use) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
          end
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StBoot;
      boot_cnt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  hazard_perf_cnt u_perf_cnt (
    .clk_i          (clk),
    .rst_i          (rst),
    .clr_i          (cnt_clr),
    .stall_inc_i    (stall_f & (state_q != StBoot)),
    .flush_inc_i    (redirect_valid),
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_hazard_ctrl;

  localparam int unsigned Boot = 4;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [4:0]  rd;
    logic        memread;
    logic        mispredict;
    logic [31:0] rpc;
    logic        mem_busy;
    logic        clr;
  } stim_t;

  // ctl = {stall_f, stall_d, stall_e, flush_d, bubble_e, redirect_valid}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] pc;
    logic [31:0] sc;
    logic [15:0] fe;
    logic [31:0] tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rd_e;
  logic        use_rs1_d, use_rs2_d, memread_e, mispredict_e, mem_busy, cnt_clr;
  logic [31:0] redirect_pc_e;
  logic        stall_f, stall_d, stall_e, flush_d, bubble_e, redirect_valid;
  logic [31:0] redirect_pc, stall_cycles;
  logic [15:0] flush_events;

  hazard_ctrl #(.BOOT_CYCLES(Boot)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .use_rs1_d      (use_rs1_d),
    .use_rs2_d      (use_rs2_d),
    .rd_e           (rd_e),
    .memread_e      (memread_e),
    .mispredict_e   (mispredict_e),
    .redirect_pc_e  (redirect_pc_e),
    .mem_busy       (mem_busy),
    .cnt_clr        (cnt_clr),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .flush_d        (flush_d),
    .bubble_e       (bubble_e),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc     = 0;

  // Reference model: boot countdown, one pending redirect slot, two counters.
  int          m_boot_left;
  bit          m_pend_v;
  logic [31:0] m_pend_pc;
  logic [31:0] m_sc;
  logic [15:0] m_fe;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want,
                       input logic [31:0] tag);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctl", {26'd0, stall_f, stall_d, stall_e, flush_d, bubble_e, redirect_valid},
            {26'd0, e.ctl}, e.tag);
      check("redirect_pc", redirect_pc, e.pc, e.tag);
      check("stall_cycles", stall_cycles, e.sc, e.tag);
      check("flush_events", {16'd0, flush_events}, {16'd0, e.fe}, e.tag);
    end
  end

  task automatic step(input stim_t s);
    exp_t e;
    bit   lu, stall_now, redir_now;
    rst           = s.rst;
    rs1_d         = s.rs1;
    rs2_d         = s.rs2;
    use_rs1_d     = s.use1;
    use_rs2_d     = s.use2;
    rd_e          = s.rd;
    memread_e     = s.memread;
    mispredict_e  = s.mispredict;
    redirect_pc_e = s.rpc;
    mem_busy      = s.mem_busy;
    cnt_clr       = s.clr;

    if (s.rst) begin
      m_boot_left = Boot;
      m_pend_v    = 0;
      m_pend_pc   = '0;
      m_sc        = '0;
      m_fe        = '0;
    end
    lu = s.memread && (s.rd != 0) &&
         ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    e.sc = m_sc;
    e.fe = m_fe;
    e.pc = '0;
    e.tag = cyc;
    stall_now = 0;
    redir_now = 0;
    if (s.rst || m_boot_left > 0) begin
      e.ctl = 6'b110100;
    end else if (s.mem_busy) begin
      e.ctl = 6'b111000;
      stall_now = 1;
    end else if (s.mispredict || m_pend_v) begin
      e.ctl = 6'b000111;
      e.pc = s.mispredict ? s.rpc : m_pend_pc;
      redir_now = 1;
    end else if (lu) begin
      e.ctl = 6'b110010;
      stall_now = 1;
    end else begin
      e.ctl = 6'b000000;
    end
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    if (!s.rst) begin
      if (m_boot_left > 0) begin
        m_boot_left--;
      end else begin
        if (s.mem_busy && s.mispredict) begin
          m_pend_v  = 1;
          m_pend_pc = s.rpc;
        end
        if (redir_now) m_pend_v = 0;
      end
      if (s.clr) begin
        m_sc = '0;
        m_fe = '0;
      end else begin
        if (stall_now) m_sc = m_sc + 32'd1;
        if (redir_now) m_fe = m_fe + 16'd1;
      end
    end
  endtask

  function automatic stim_t rand_s();
    stim_t s;
    s            = '0;
    s.rst        = ($urandom_range(99) < 2);
    s.rs1        = 5'($urandom_range(3));
    s.rs2        = 5'($urandom_range(3));
    s.use1       = 1'($urandom_range(1));
    s.use2       = 1'($urandom_range(1));
    s.rd         = 5'($urandom_range(3));
    s.memread    = ($urandom_range(2) == 0);
    s.mispredict = ($urandom_range(99) < 15);
    s.rpc        = $urandom();
    s.mem_busy   = ($urandom_range(3) == 0);
    s.clr        = ($urandom_range(99) < 4);
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    m_boot_left = Boot;
    m_pend_v = 0;
    m_pend_pc = '0;
    m_sc = '0;
    m_fe = '0;
    @(posedge clk);
    #1;

    // Reset then boot hold with no stimulus.
    s = '0;
    s.rst = 1'b1;
    repeat (2) step(s);
    s.rst = 1'b0;
    repeat (7) step(s);

    // Load-use on rs2, then the same with rd_e = x0.
    s = '0;
    s.memread = 1'b1;
    s.rd = 5'd5;
    s.rs2 = 5'd5;
    s.use2 = 1'b1;
    step(s);
    s.rd = 5'd0;
    s.rs2 = 5'd0;
    step(s);

    // Mispredict redirect.
    s = '0;
    s.mispredict = 1'b1;
    s.rpc = 32'h0000_0100;
    step(s);
    s = '0;
    step(s);

    // Counter clear, then three busy cycles with a mispredict in the second.
    s.clr = 1'b1;
    step(s);
    s = '0;
    s.mem_busy = 1'b1;
    step(s);
    s.mispredict = 1'b1;
    s.rpc = 32'h0000_0200;
    step(s);
    s.mispredict = 1'b0;
    step(s);
    s = '0;
    repeat (2) step(s);

    // Mispredict together with load-use; then load-use with a counter clear.
    s = '0;
    s.memread = 1'b1;
    s.rd = 5'd7;
    s.rs1 = 5'd7;
    s.use1 = 1'b1;
    s.mispredict = 1'b1;
    s.rpc = 32'h0000_0300;
    step(s);
    s.mispredict = 1'b0;
    s.clr = 1'b1;
    step(s);
    s = '0;
    step(s);

    // Reset while waiting on memory with a redirect pending.
    s = '0;
    s.mem_busy = 1'b1;
    s.mispredict = 1'b1;
    s.rpc = 32'h0000_0400;
    step(s);
    s.mispredict = 1'b0;
    step(s);
    s.rst = 1'b1;
    step(s);
    s = '0;
    repeat (8) step(s);

    for (int i = 0; i < 2000; i++) step(rand_s());

    s = '0;
    step(s);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter BOOT_CYCLES, default 4: post-reset cycles during which the front end is held and decode is flushed.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 rs1_d, rs2_d  in  5 each  source registers of the instruction in decode.
REQ-005 use_rs1_d, use_rs2_d  in  1 each  decode instruction actually reads rs1/rs2.
REQ-006 rd_e  in  5  destination register of the instruction in execute.
REQ-007 memread_e  in  1  instruction in execute is a load.
REQ-008 mispredict_e  in  1  single-cycle pulse: branch/jump resolved in execute disagrees with prediction.
REQ-009 redirect_pc_e  in  32  correct target, valid with mispredict_e.
REQ-010 mem_busy  in  1  data memory cannot complete this cycle.
REQ-011 cnt_clr  in  1  synchronous clear of both performance counters.
REQ-012 stall_f, stall_d  out  1 each  hold PC register / decode register.
REQ-013 stall_e  out  1  hold execute and later pipeline registers.
REQ-014 flush_d  out  1  load NOP (32'h33) into decode register at next edge.
REQ-015 bubble_e  out  1  load NOP control into execute register at next edge.
REQ-016 redirect_valid, redirect_pc  out  1, 32  fetch takes redirect_pc as next PC.
REQ-017 stall_cycles  out  32  count of non-boot cycles with stall_f=1, wraps at 2^32.
REQ-018 flush_events  out  16  count of redirects issued, wraps at 2^16.

Function
REQ-019 FSM states BOOT, RUN, MEM_WAIT; registered state, Mealy outputs computed combinationally from state and inputs in the same cycle.
REQ-020 BOOT: stall_f=stall_d=flush_d=1, all other control outputs 0; 8-bit counter counts BOOT_CYCLES cycles, then RUN; mispredict_e and mem_busy ignored.
REQ-021 Load-use hazard LU = memread_e & rd_e!=0 & ((use_rs1_d & rs1_d==rd_e) | (use_rs2_d & rs2_d==rd_e)).
REQ-022 RUN priority 1, mem_busy=1: stall_f=stall_d=stall_e=1, no flush/bubble/redirect; next state MEM_WAIT.
REQ-023 RUN priority 2, mispredict_e=1 or pend_valid=1: redirect_valid=1, flush_d=1, bubble_e=1, redirect_pc = mispredict_e ? redirect_pc_e : pend_pc; pend_valid cleared; flush_events +1.
REQ-024 RUN priority 3, LU=1: stall_f=stall_d=1, bubble_e=1, for exactly that cycle; no redirect.
REQ-025 RUN otherwise: all control outputs 0; redirect_pc = 0 whenever redirect_valid=0.
REQ-026 MEM_WAIT with mem_busy=1: same outputs as REQ-022; stay.
REQ-027 MEM_WAIT with mem_busy=0: outputs per RUN priorities 2-4 that cycle; next state RUN.
REQ-028 mispredict_e coincident with mem_busy=1 (either state): latch pend_pc=redirect_pc_e, pend_valid=1; redirect issued on first cycle mem_busy=0 per REQ-023.
REQ-029 A second mispredict_e while pend_valid=1 and mem_busy=1 overwrites pend_pc (younger redirect wins).
REQ-030 stall_cycles increments each cycle stall_f=1 in RUN or MEM_WAIT; cnt_clr=1 zeroes both counters and overrides same-cycle increment.

Reset
REQ-031 rst=1 forces state=BOOT, boot counter=0, pend_valid=0, pend_pc=0, counters=0, at any time including mid-MEM_WAIT or with redirect pending.
REQ-032 During and immediately after reset, outputs take BOOT values: stall_f=stall_d=flush_d=1, stall_e=bubble_e=redirect_valid=0, redirect_pc=0, counters 0.

Structure
REQ-033 State enum and the NOP constant 32'h33 live in shared package core_pkg; other modules use the same NOP constant.
REQ-034 One sub-module, hazard_perf_cnt (both counters plus clear), is instantiated; all else is flat.

Verification
REQ-035 Reset released, no stimulus -> stall_f=flush_d=1 for exactly 4 cycles, then all 0; stall_cycles=0.
REQ-036 RUN, memread_e=1, rd_e=5, rs2_d=5, use_rs2_d=1 -> one cycle stall_f=stall_d=bubble_e=1; rd_e=0 same case -> no stall.
REQ-037 mispredict_e pulse, redirect_pc_e=32'h0000_0100 -> same cycle redirect_valid=1, redirect_pc=32'h100, flush_d=bubble_e=1; flush_events 0->1.
REQ-038 mem_busy high 3 cycles, mispredict_e pulse (32'h200) in cycle 2 -> stalls 3 cycles, redirect to 32'h200 in cycle 4, stall_cycles=3.
REQ-039 mispredict_e and LU same cycle -> redirect/flush only, stall_f=0; cnt_clr with stall same cycle -> stall_cycles=0 next cycle.
REQ-040 rst asserted in MEM_WAIT with redirect pending -> BOOT values immediately; no redirect after release.
